// File: rtl/load_store_queue.sv
// load_store_queue
//   In-order load/store queue for an out-of-order core. Entries are allocated
//   at the tail and snoop two result buses for their operands. Each cycle the
//   oldest entry with rs1 ready has its address computed. A four-state head
//   FSM issues one memory access at a time. Stores wait for the ROB commit
//   before they write. Loads broadcast their extended result one cycle after
//   mem_done.
// Ports
//   clk, rst          clock; asynchronous active-low reset (release is synced)
//   flush             mispredict flush
//   in_*              enqueue request (in_ready = !full)
//   cdb0_*, cdb1_*    result buses (cdb0 has priority)
//   st_rdy_*          one-cycle pulse: the store at head is ready to commit
//   commit_*          ROB commit of a store
//   mem_*             single outstanding memory request; mem_done ends it
//   ld_*              one-cycle load result broadcast
//   count/full/empty  registered occupancy
module load_store_queue #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_store,
  input  logic [2:0]                 in_funct3,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [DATA_W-1:0]          in_rs1_val,
  input  logic [DATA_W-1:0]          in_rs2_val,
  input  logic [TAG_W-1:0]           in_rs1_tag,
  input  logic [TAG_W-1:0]           in_rs2_tag,
  input  logic [31:0]                in_imm,
  input  logic                       cdb0_valid,
  input  logic [TAG_W-1:0]           cdb0_tag,
  input  logic [DATA_W-1:0]          cdb0_data,
  input  logic                       cdb1_valid,
  input  logic [TAG_W-1:0]           cdb1_tag,
  input  logic [DATA_W-1:0]          cdb1_data,
  output logic                       st_rdy_valid,
  output logic [TAG_W-1:0]           st_rdy_tag,
  input  logic                       commit_valid,
  input  logic [TAG_W-1:0]           commit_tag,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [1:0]                 mem_size,
  input  logic                       mem_done,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       ld_valid,
  output logic [TAG_W-1:0]           ld_tag,
  output logic [DATA_W-1:0]          ld_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] NOTAG = '1;

  typedef struct packed {
    logic              vld;
    logic              is_store;
    logic [2:0]        funct3;
    logic [TAG_W-1:0]  tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_val;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_val;
    logic [31:0]       imm;
    logic [ADDR_W-1:0] addr;
    logic              addr_ok;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } opnd_t;

  typedef enum logic [1:0] {IDLE, ST_WAIT, MEM, DRAIN} state_t;

  // Reset asserts immediately; release is delayed two clocks so every flop
  // leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       arst_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign arst_n = rst_sync[1];

  entry_t             q [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  state_t             state, state_n;
  logic               killed;     // store in flight whose entry was flushed
  logic               cur_store;
  logic [2:0]         cur_f3;
  logic [TAG_W-1:0]   cur_tag;

  // An operand waiting on a tag takes the first bus that carries that tag.
  // A NOTAG operand never matches, so a NOTAG bus is ignored as well.
  function automatic opnd_t snoop(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    opnd_t r;
    r.tag = t;
    r.val = v;
    if (t != NOTAG) begin
      if (cdb0_valid && cdb0_tag == t) begin
        r.tag = NOTAG; r.val = cdb0_data;
      end else if (cdb1_valid && cdb1_tag == t) begin
        r.tag = NOTAG; r.val = cdb1_data;
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] ld_ext(input logic [2:0] f3, input logic [DATA_W-1:0] r);
    case (f3)
      3'b000:  return {{(DATA_W-8){r[7]}},   r[7:0]};
      3'b001:  return {{(DATA_W-16){r[15]}}, r[15:0]};
      3'b100:  return {{(DATA_W-8){1'b0}},   r[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}},  r[15:0]};
      default: return r;
    endcase
  endfunction

  // ---------------- combinational control ----------------
  entry_t            head_e, new_e;
  opnd_t             s1 [DEPTH];
  opnd_t             s2 [DEPTH];
  opnd_t             n1, n2;
  logic              enq;
  logic              ag_hit;
  logic [PTR_W-1:0]  ag_idx, idx;
  logic [ADDR_W-1:0] ag_addr;
  logic [CNT_W-1:0]  count_n;
  logic              issue_ld, issue_st, st_rdy, deq, ld_fire;

  assign head_e = q[head];
  assign enq    = in_valid && in_ready && !flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s1[i] = snoop(q[i].rs1_tag, q[i].rs1_val);
      s2[i] = snoop(q[i].rs2_tag, q[i].rs2_val);
    end
    n1 = snoop(in_rs1_tag, in_rs1_val);
    n2 = snoop(in_rs2_tag, in_rs2_val);
    new_e          = '0;
    new_e.vld      = 1'b1;
    new_e.is_store = in_is_store;
    new_e.funct3   = in_funct3;
    new_e.tag      = in_tag;
    new_e.rs1_tag  = n1.tag;
    new_e.rs1_val  = n1.val;
    new_e.rs2_tag  = n2.tag;
    new_e.rs2_val  = n2.val;
    new_e.imm      = in_imm;
  end

  // Address generation: scan from youngest to oldest so the oldest
  // candidate is the one left selected.
  always_comb begin
    ag_hit = 1'b0;
    ag_idx = '0;
    idx    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      idx = head + PTR_W'(i);
      if (q[idx].vld && !q[idx].addr_ok && q[idx].rs1_tag == NOTAG) begin
        ag_hit = 1'b1;
        ag_idx = idx;
      end
    end
    ag_addr = ADDR_W'(q[ag_idx].rs1_val) + ADDR_W'(signed'(q[ag_idx].imm));
  end

  // Head FSM next state and per-cycle actions
  always_comb begin
    state_n  = state;
    issue_ld = 1'b0;
    issue_st = 1'b0;
    st_rdy   = 1'b0;
    deq      = 1'b0;
    ld_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && head_e.vld && head_e.addr_ok) begin
          if (!head_e.is_store) begin
            state_n  = MEM;
            issue_ld = 1'b1;
          end else if (head_e.rs2_tag == NOTAG) begin
            state_n = ST_WAIT;
            st_rdy  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (flush) state_n = IDLE;
        else if (commit_valid && commit_tag == head_e.tag) begin
          state_n  = MEM;
          issue_st = 1'b1;
        end
      end
      MEM: begin
        if (mem_done) begin
          // A flush landing with mem_done still ends the access here;
          // waiting in DRAIN would wait for a done that never comes.
          state_n = IDLE;
          deq     = !flush && !killed;
          ld_fire = !cur_store && !flush;
        end else if (flush && !cur_store) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    if (flush) count_n = '0;
    else       count_n = count + CNT_W'(enq) - CNT_W'(deq);
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      in_ready <= 1'b1;
      killed   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].vld) begin
          q[i].rs1_tag <= s1[i].tag;
          q[i].rs1_val <= s1[i].val;
          q[i].rs2_tag <= s2[i].tag;
          q[i].rs2_val <= s2[i].val;
        end
      end
      if (ag_hit) begin
        q[ag_idx].addr    <= ag_addr;
        q[ag_idx].addr_ok <= 1'b1;
      end
      if (deq) begin
        q[head].vld <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (enq) begin
        q[tail] <= new_e;
        tail    <= tail + PTR_W'(1);
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) q[i].vld <= 1'b0;
        head <= '0;
        tail <= '0;
      end
      killed   <= (state == MEM) && (state_n == MEM) && (killed || flush);
      count    <= count_n;
      full     <= (count_n == CNT_W'(DEPTH));
      empty    <= (count_n == '0);
      in_ready <= (count_n != CNT_W'(DEPTH));
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_rdy_valid <= 1'b0;
      st_rdy_tag   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_size     <= '0;
      ld_valid     <= 1'b0;
      ld_tag       <= '0;
      ld_data      <= '0;
      cur_store    <= 1'b0;
      cur_f3       <= '0;
      cur_tag      <= '0;
    end else begin
      st_rdy_valid <= st_rdy;
      if (st_rdy) st_rdy_tag <= head_e.tag;
      ld_valid <= ld_fire;
      if (ld_fire) begin
        ld_tag  <= cur_tag;
        ld_data <= ld_ext(cur_f3, mem_rdata);
      end
      // Request fields are loaded once at issue and held until mem_done.
      if (issue_ld || issue_st) begin
        mem_req   <= 1'b1;
        mem_we    <= issue_st;
        mem_addr  <= head_e.addr;
        mem_size  <= head_e.funct3[1:0];
        if (issue_st) mem_wdata <= head_e.rs2_val;
        cur_store <= issue_st;
        cur_f3    <= head_e.funct3;
        cur_tag   <= head_e.tag;
      end else if ((state == MEM || state == DRAIN) && mem_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
module tb_load_store_queue;
  localparam logic [4:0] NT = 5'h1f;

  logic        clk, rst, flush, in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_tag, in_rs1_tag, in_rs2_tag;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic        cdb0_valid, cdb1_valid;
  logic [4:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic        st_rdy_valid;
  logic [4:0]  st_rdy_tag;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        ld_valid;
  logic [4:0]  ld_tag;
  logic [31:0] ld_data;
  logic [4:0]  count;
  logic        full, empty;

  load_store_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_tag(in_tag),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .in_imm(in_imm),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .st_rdy_valid(st_rdy_valid), .st_rdy_tag(st_rdy_tag),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int st_hi = 0, nstores = 0;
  logic [4:0] srq[$];

  // Record every st_rdy pulse just after the edge that raises it.
  always @(posedge clk) begin
    #1;
    if (st_rdy_valid) begin
      srq.push_back(st_rdy_tag);
      st_hi++;
    end
  end

  typedef struct { bit st; bit [2:0] f3; logic [4:0] tag; logic [31:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { logic [4:0] tag; logic [31:0] val; } pend_t;
  op_t   mq[$];
  pend_t pq[$];
  bit [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Expected load result from the RISC-V funct3 rules.
  function automatic logic [31:0] ld_model(input bit [2:0] f3, input logic [31:0] r);
    case (f3)
      3'd0:    return 32'(signed'(r[7:0]));
      3'd1:    return 32'(signed'(r[15:0]));
      3'd4:    return 32'(r[7:0]);
      3'd5:    return 32'(r[15:0]);
      default: return r;
    endcase
  endfunction

  task automatic enq(input bit st, input bit [2:0] f3, input logic [4:0] tg,
                     input logic [31:0] r1, input logic [4:0] t1,
                     input logic [31:0] r2, input logic [4:0] t2, input logic [31:0] imm);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_tag = tg;
    in_rs1_val = r1; in_rs1_tag = t1; in_rs2_val = r2; in_rs2_tag = t2; in_imm = imm;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cdb(input bit b, input logic [4:0] t, input logic [31:0] d);
    if (b) begin cdb1_valid = 1'b1; cdb1_tag = t; cdb1_data = d; end
    else   begin cdb0_valid = 1'b1; cdb0_tag = t; cdb0_data = d; end
    @(negedge clk);
    cdb0_valid = 1'b0; cdb1_valid = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!mem_req && n < 80) begin @(negedge clk); n++; end
    chk({nm, "_req_seen"}, mem_req, 1);
  endtask

  task automatic pulse_done(input logic [31:0] rd);
    mem_done = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_done = 1'b0; mem_rdata = $urandom;
  endtask

  task automatic svc_load(input string nm, input logic [31:0] addr, input logic [1:0] sz,
                          input logic [4:0] tg, input logic [31:0] rd, input logic [31:0] exp);
    wait_req(nm);
    chk({nm, "_addr"}, mem_addr, addr);
    chk({nm, "_size"}, mem_size, sz);
    chk({nm, "_we"}, mem_we, 0);
    @(negedge clk);
    chk({nm, "_addr_hold"}, {mem_req, mem_addr}, {1'b1, addr});
    pulse_done(rd);
    chk({nm, "_ld_valid"}, ld_valid, 1);
    chk({nm, "_ld_tag"}, ld_tag, tg);
    chk({nm, "_ld_data"}, ld_data, exp);
    chk({nm, "_req_fall"}, mem_req, 0);
    @(negedge clk);
    chk({nm, "_ld_pulse"}, ld_valid, 0);
  endtask

  task automatic svc_store(input string nm, input logic [4:0] tg, input logic [31:0] addr,
                           input logic [1:0] sz, input logic [31:0] wd, input bit wrong_first);
    int n = 0;
    while (srq.size() == 0 && n < 80) begin @(negedge clk); n++; end
    chk({nm, "_strdy_seen"}, srq.size() > 0, 1);
    if (srq.size() > 0) chk({nm, "_strdy_tag"}, srq.pop_front(), tg);
    nstores++;
    if (wrong_first) begin
      commit_valid = 1'b1; commit_tag = tg ^ 5'h1;
      @(negedge clk);
      commit_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_wrong_commit"}, mem_req, 0);
    end
    commit_valid = 1'b1; commit_tag = tg;
    @(negedge clk);
    commit_valid = 1'b0;
    chk({nm, "_req"}, mem_req, 1);
    chk({nm, "_we"}, mem_we, 1);
    chk({nm, "_addr"}, mem_addr, addr);
    chk({nm, "_wdata"}, mem_wdata, wd);
    chk({nm, "_size"}, mem_size, sz);
    pulse_done($urandom);
    chk({nm, "_req_fall"}, mem_req, 0);
    chk({nm, "_no_ld"}, ld_valid, 0);
  endtask

  bit          st;
  bit [2:0]    f3;
  logic [31:0] r1, r2, imm, rd;
  logic [4:0]  t1, t2, tg;
  int          k;
  op_t         o;
  pend_t       p;

  initial begin
    rst = 1'b1; flush = 0; in_valid = 0; in_is_store = 0; in_funct3 = 0; in_tag = 0;
    in_rs1_val = 0; in_rs2_val = 0; in_rs1_tag = NT; in_rs2_tag = NT; in_imm = 0;
    cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0; cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
    commit_valid = 0; commit_tag = 0; mem_done = 0; mem_rdata = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_flags", {full, empty, in_ready}, 3'b011);
    chk("rst_count", count, 0);
    chk("rst_pulses", {st_rdy_valid, ld_valid}, 0);
    chk("rst_data", {mem_addr, mem_wdata, ld_data}, 0);
    chk("rst_tags", {st_rdy_tag, ld_tag, mem_size}, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // LW, then LB / LBU sign handling
    enq(0, 3'd2, 5'd1, 32'h1000, NT, 0, NT, 32'd4);
    chk("lw_count", count, 1);
    svc_load("lw", 32'h1004, 2'd2, 5'd1, 32'h12345678, 32'h12345678);
    chk("lw_empty", {empty, count}, {1'b1, 5'd0});
    enq(0, 3'd0, 5'd2, 32'h2000, NT, 0, NT, 32'hFFFFFFFF);
    svc_load("lb", 32'h1FFF, 2'd0, 5'd2, 32'h00000080, 32'hFFFFFF80);
    enq(0, 3'd4, 5'd3, 32'h2000, NT, 0, NT, 32'd1);
    svc_load("lbu", 32'h2001, 2'd0, 5'd3, 32'h00000080, 32'h00000080);

    // Store waits for rs2 from cdb1, ignores a wrong commit
    enq(1, 3'd2, 5'd3, 32'h3000, NT, 32'h0, 5'd3, 32'h10);
    repeat (4) @(negedge clk);
    chk("sw_no_early_rdy", srq.size(), 0);
    cdb(1, 5'd3, 32'hAB);
    svc_store("sw", 5'd3, 32'h3010, 2'd2, 32'hAB, 1);

    // Both buses carry the same tag: cdb0 wins
    enq(1, 3'd1, 5'd6, 32'h300, NT, 32'h0, 5'd2, 32'h0);
    cdb0_tag = 5'd2; cdb0_data = 32'd5; cdb1_tag = 5'd2; cdb1_data = 32'd9;
    cdb0_valid = 1; cdb1_valid = 1;
    @(negedge clk);
    cdb0_valid = 0; cdb1_valid = 0;
    svc_store("cdb_prio", 5'd6, 32'h300, 2'd1, 32'd5, 0);

    // Same-cycle bypass at enqueue
    cdb0_valid = 1; cdb0_tag = 5'd4; cdb0_data = 32'h2000;
    enq(0, 3'd5, 5'd7, 32'hDEAD, 5'd4, 0, NT, 32'h8);
    cdb0_valid = 0;
    svc_load("bypass", 32'h2008, 2'd1, 5'd7, 32'h0000F00D, 32'h0000F00D);

    // Fill to 16 with loads blocked on tag 8
    for (int i = 0; i < 16; i++) enq(0, 3'd2, 5'(i), 32'h0, 5'd8, 0, NT, 32'(i * 4));
    chk("fill_flags", {full, in_ready, count}, {1'b1, 1'b0, 5'd16});
    enq(0, 3'd2, 5'd20, 32'h0, 5'd8, 0, NT, 32'h999);
    chk("fill_drop_count", count, 16);
    cdb(0, 5'd8, 32'h100);
    svc_load("fill0", 32'h100, 2'd2, 5'd0, 32'h11, 32'h11);
    chk("fill_after_deq", {full, in_ready, count}, {1'b0, 1'b1, 5'd15});
    enq(0, 3'd2, 5'd21, 32'h5000, NT, 0, NT, 32'h777);
    chk("fill_wrap", {full, count}, {1'b1, 5'd16});
    for (int i = 1; i < 16; i++) begin
      rd = $urandom;
      svc_load("fill", 32'h100 + 32'(i * 4), 2'd2, 5'(i), rd, rd);
    end
    svc_load("fill_last", 32'h5777, 2'd2, 5'd21, 32'h77, 32'h77);
    chk("fill_empty", {empty, count}, {1'b1, 5'd0});

    // Flush while a load is in MEM
    enq(0, 3'd2, 5'd1, 32'h4000, NT, 0, NT, 0);
    wait_req("fl_a");
    enq(0, 3'd2, 5'd2, 32'h4100, NT, 0, NT, 0);
    flush = 1; @(negedge clk); flush = 0;
    chk("fl_count", {empty, count}, {1'b1, 5'd0});
    chk("fl_req_held", mem_req, 1);
    enq(0, 3'd2, 5'd3, 32'h4200, NT, 0, NT, 0);
    chk("fl_drain_enq", count, 1);
    repeat (3) @(negedge clk);
    chk("fl_drain_hold", {mem_req, mem_addr}, {1'b1, 32'h4000});
    pulse_done(32'hBAD);
    chk("fl_no_ld", ld_valid, 0);
    chk("fl_req_fall", mem_req, 0);
    svc_load("fl_c", 32'h4200, 2'd2, 5'd3, 32'h42, 32'h42);

    // Randomised batches against the queue model
    for (int b = 0; b < 20; b++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        st  = 1'($urandom_range(0, 1));
        f3  = st ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
        r1  = $urandom; r2 = $urandom; imm = $urandom;
        tg  = 5'($urandom_range(0, 30));
        t1  = NT; t2 = NT;
        if ($urandom_range(0, 2) == 0) begin t1 = 5'(10 + 2 * j); pq.push_back('{t1, r1}); end
        if (st && $urandom_range(0, 1) == 1) begin t2 = 5'(11 + 2 * j); pq.push_back('{t2, r2}); end
        mq.push_back('{st, f3, tg, r1 + imm, r2});
        enq(st, f3, tg, (t1 == NT) ? r1 : 32'hDEAD, t1, (t2 == NT) ? r2 : 32'hBEEF, t2, imm);
      end
      chk("rnd_count", count, 5'(k));
      while (pq.size() > 0) begin
        p = pq.pop_front();
        cdb(1'($urandom_range(0, 1)), p.tag, p.val);
      end
      while (mq.size() > 0) begin
        o = mq.pop_front();
        if (o.st) svc_store("rnd_st", o.tag, o.addr, o.f3[1:0], o.wdata, 0);
        else begin
          rd = $urandom;
          svc_load("rnd_ld", o.addr, o.f3[1:0], o.tag, rd, ld_model(o.f3, rd));
        end
      end
      chk("rnd_empty", empty, 1);
    end

    // Reset in the middle of a load
    enq(0, 3'd2, 5'd9, 32'h6000, NT, 0, NT, 0);
    wait_req("rst_mid");
    rst = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_count", {empty, count}, {1'b1, 5'd0});
    @(negedge clk);
    pulse_done(32'h66);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid_no_ld", ld_valid, 0);
      @(negedge clk);
    end
    chk("rst_mid_idle", {mem_req, count}, 0);

    chk("strdy_pulse_cycles", st_hi, nstores);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 The block SHALL take these parameters: DEPTH, 16, number of queue entries (power of 2, at least 2).
REQ-002 The block SHALL take these parameters: TAG_W, 5, rename-tag width; the all-ones value is NOTAG (operand ready, no producer).
REQ-003 The block SHALL take these parameters: DATA_W, 32, operand and data width; ADDR_W, 32, address width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  mispredict flush
- in_valid  in  1  enqueue request
- in_ready  out  1  equals !full
- in_is_store  in  1  1 = store, 0 = load
- in_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- in_tag  in  TAG_W  ROB tag of the instruction
- in_rs1_val, in_rs2_val  in  DATA_W  operand values
- in_rs1_tag, in_rs2_tag  in  TAG_W  operand producer tags
- in_imm  in  32  sign-extended offset
- cdbK_valid / cdbK_tag / cdbK_data  in  1 / TAG_W / DATA_W  result buses, K = 0 and 1
- st_rdy_valid / st_rdy_tag  out  1 / TAG_W  store at head is ready to commit
- commit_valid / commit_tag  in  1 / TAG_W  ROB commits a store
- mem_req / mem_we  out  1 / 1  memory request / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_size  out  2  0 = byte, 1 = half, 2 = word
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  DATA_W  right-aligned load data
- ld_valid / ld_tag / ld_data  out  1 / TAG_W / DATA_W  load result broadcast
- count  out  clog2(DEPTH+1)  occupancy
- full, empty  out  1  occupancy flags

Function
REQ-006 The queue SHALL be a circular buffer with head and tail pointers that wrap modulo DEPTH; count SHALL be registered; full SHALL be count==DEPTH and empty SHALL be count==0.
REQ-007 The block SHALL enqueue at the tail when in_valid && in_ready; full SHALL block enqueue even when a dequeue occurs in the same cycle.
REQ-008 Operand capture at enqueue SHALL bypass a same-cycle CDB whose tag matches the operand tag: the entry's tag becomes NOTAG and the CDB data is stored.
REQ-009 Every valid entry SHALL snoop both CDBs every cycle; a bus with tag NOTAG or valid=0 SHALL be ignored; if both buses match the same tag, cdb0 SHALL win.
REQ-010 The block SHALL compute one address per cycle, for the oldest entry with rs1 ready and address not yet computed: addr = rs1 + imm, modulo 2^ADDR_W.
REQ-011 The head FSM SHALL have four states: IDLE, ST_WAIT, MEM, DRAIN.
REQ-012 In IDLE with a load at head and its address ready, the FSM SHALL go to MEM, drive mem_req=1 and mem_we=0, and set size from funct3.
REQ-013 In IDLE with a store at head and both address and rs2 ready, the block SHALL pulse st_rdy_valid for exactly one cycle with the head tag and go to ST_WAIT.
REQ-014 In ST_WAIT, commit_valid with commit_tag equal to the head tag SHALL move the FSM to MEM with mem_we=1 and mem_wdata=rs2; a non-matching commit SHALL be ignored.
REQ-015 mem_req, mem_addr, mem_we, mem_wdata and mem_size SHALL be held stable from MEM entry until mem_done, and mem_req SHALL fall in the cycle after mem_done.
REQ-016 On mem_done, the block SHALL dequeue the head and return to IDLE; a new head request SHALL NOT issue before the following cycle.
REQ-017 For a load, the cycle after mem_done SHALL drive ld_valid=1 and ld_tag, with ld_data sign-extended (LB, LH) or zero-extended (LBU, LHU, LW unchanged) from the low bits.
REQ-018 Flush in IDLE or ST_WAIT SHALL clear all entries, set head=tail=count=0, and go to IDLE.
REQ-019 Flush in MEM with a store SHALL clear all entries and let the write complete.
REQ-020 Flush in MEM with a load SHALL clear all entries and go to DRAIN; DRAIN SHALL wait for mem_done, discard the data, not assert ld_valid, and then go to IDLE.
REQ-021 Enqueue SHALL be ignored in the cycle flush is high; enqueue SHALL be allowed in DRAIN, but head issue SHALL wait for IDLE.
REQ-022 All outputs SHALL be registered; the pulse outputs (st_rdy_valid, ld_valid) SHALL be exactly one cycle wide.

Reset
REQ-023 On rst low, the block SHALL asynchronously clear all entries, pointers and count, and set the FSM to IDLE.
REQ-024 On rst low, outputs SHALL be: mem_req=0, mem_we=0, st_rdy_valid=0, ld_valid=0, full=0, empty=1, in_ready=1, count=0, and all data, address and tag outputs = 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction without a ld_valid pulse; reset release SHALL be synchronised to clk.

Verification
REQ-026 Enqueue LW with rs1=0x1000 ready and imm=4; mem_done with rdata 0x12345678 two cycles after mem_req -> mem_addr=0x1004, mem_size=2, then ld_valid with ld_data 0x12345678.
REQ-027 LB with rdata 0x00000080 -> ld_data 0xFFFFFF80; LBU with the same rdata -> ld_data 0x00000080.
REQ-028 Enqueue SW with rs2_tag=3; cdb1 tag 3 carries data 0xAB -> one st_rdy_valid pulse; commit_tag=3 -> write to mem_wdata 0xAB; a commit with another tag first -> no request.
REQ-029 Fill 16 entries -> full=1, in_ready=0, a 17th in_valid is dropped; tail wraps to 0 after a dequeue and count returns to 16 after re-enqueue.
REQ-030 Flush during a load in MEM -> count=0 next cycle; later mem_done -> no ld_valid; the next enqueued load issues normally.
REQ-031 Both CDBs carry tag 2 in the same cycle with data 5 and 9 -> the waiting operand captures 5.
